// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: shared types and constants
// for the fetch/data memory-bus arbiter.
package mem_bus_arbiter_pkg;

  localparam int WORD_SIZE_D = 16;
  localparam int ADDR_SIZE_D = 16;

  // Wide all-ones word; sliced to the data width on a timed-out access.
  localparam logic [63:0] ERR_FILL = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_GAP
  } state_e;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: core-side request ports and
// memory-side strobes of the arbiter.
interface mem_bus_arbiter_if
  import mem_bus_arbiter_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_D,
  parameter int ADDR_SIZE = ADDR_SIZE_D
) ();

  logic                 if_req;
  logic [ADDR_SIZE-1:0] if_addr;
  logic                 if_ready;
  logic [WORD_SIZE-1:0] if_data;
  logic                 d_req;
  logic                 d_we;
  logic [ADDR_SIZE-1:0] d_addr;
  logic [WORD_SIZE-1:0] d_wdata;
  logic                 d_ready;
  logic [WORD_SIZE-1:0] d_rdata;
  logic                 bus_err;
  logic                 busy;
  logic                 readM;
  logic                 writeM;
  logic [ADDR_SIZE-1:0] address;
  logic                 inputReady;
  logic                 ackOutput;

  modport master (
    input  if_req, if_addr,
    input  d_req, d_we, d_addr, d_wdata,
    input  inputReady, ackOutput,
    output if_ready, if_data,
    output d_ready, d_rdata,
    output bus_err, busy,
    output readM, writeM, address
  );

  modport slave (
    output if_req, if_addr,
    output d_req, d_we, d_addr, d_wdata,
    output inputReady, ackOutput,
    input  if_ready, if_data,
    input  d_ready, d_rdata,
    input  bus_err, busy,
    input  readM, writeM, address
  );

endinterface

// File: rtl/mem_bus_arbiter_timer.sv
// mem_wait_timer: saturating wait counter that flags
// the last allowed cycle of a memory access.
module mem_wait_timer #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  if (TIMEOUT_CYCLES > 0) begin : g_tmr
    localparam int W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);
    localparam logic [W-1:0] MAX  = W'(TIMEOUT_CYCLES);

    logic [W-1:0] cnt_q, cnt_d;

    // Count waiting cycles, saturating at the limit.
    always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
        cnt_d = '0;
      else if (en_i && cnt_q != MAX)
        cnt_d = cnt_q + 1'b1;
    end

    // Counter register.
    always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
    end

    assign expired_o = en_i & (cnt_q >= LAST);
  end else begin : g_none
    logic unused_tmr;
    assign unused_tmr = ^{clk, reset, clr_i, en_i};
    assign expired_o  = 1'b0;
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: serialises fetch and data accesses
// onto a single-port memory read/write handshake.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int WORD_SIZE      = WORD_SIZE_D,
  parameter int ADDR_SIZE      = ADDR_SIZE_D,
  parameter int TIMEOUT_CYCLES = 15,
  parameter int IF_PRIORITY    = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_bus_arbiter_if.master    bus,
  inout  wire  [WORD_SIZE-1:0] data
);

  localparam logic [WORD_SIZE-1:0] ERR_W =
    ERR_FILL[WORD_SIZE-1:0];
  localparam logic IF_WINS = (IF_PRIORITY != 0);

  state_e               state_q, state_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0] wdata_q, wdata_d;
  logic [WORD_SIZE-1:0] if_data_q, if_data_d;
  logic [WORD_SIZE-1:0] d_rdata_q, d_rdata_d;
  logic                 own_if_q, own_if_d;
  logic                 err_q, err_d;
  logic                 gnt_if, gnt_d;
  logic                 in_acc, tmr_exp;

  assign gnt_if = bus.if_req & (~bus.d_req | IF_WINS);
  assign gnt_d  = bus.d_req & ~gnt_if;
  assign in_acc = (state_q == S_RD) | (state_q == S_WR);

  mem_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmr (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (~in_acc),
    .en_i     (in_acc),
    .expired_o(tmr_exp)
  );

  // Next-state: arbitrate in IDLE/GAP, wait for response or timeout.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    if_data_d = if_data_q;
    d_rdata_d = d_rdata_q;
    own_if_d  = own_if_q;
    err_d     = 1'b0;
    unique case (state_q)
      S_IDLE, S_GAP: begin
        state_d = S_IDLE;
        if (gnt_if) begin
          state_d  = S_RD;
          own_if_d = 1'b1;
          addr_d   = bus.if_addr;
        end else if (gnt_d) begin
          state_d  = bus.d_we ? S_WR : S_RD;
          own_if_d = 1'b0;
          addr_d   = bus.d_addr;
          wdata_d  = bus.d_wdata;
        end
      end
      S_RD: begin
        if (bus.inputReady) begin
          state_d = S_GAP;
          if (own_if_q) if_data_d = data;
          else          d_rdata_d = data;
        end else if (tmr_exp) begin
          state_d = S_GAP;
          err_d   = 1'b1;
          if (own_if_q) if_data_d = ERR_W;
          else          d_rdata_d = ERR_W;
        end
      end
      S_WR: begin
        if (bus.ackOutput) begin
          state_d = S_GAP;
        end else if (tmr_exp) begin
          state_d   = S_GAP;
          err_d     = 1'b1;
          d_rdata_d = ERR_W;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and latched request registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      if_data_q <= '0;
      d_rdata_q <= '0;
      own_if_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      if_data_q <= if_data_d;
      d_rdata_q <= d_rdata_d;
      own_if_q  <= own_if_d;
      err_q     <= err_d;
    end
  end

  assign bus.readM    = (state_q == S_RD);
  assign bus.writeM   = (state_q == S_WR);
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.address  = addr_q;
  assign bus.if_ready = (state_q == S_GAP) & own_if_q;
  assign bus.d_ready  = (state_q == S_GAP) & ~own_if_q;
  assign bus.bus_err  = err_q;
  assign bus.if_data  = if_data_q;
  assign bus.d_rdata  = d_rdata_q;

  assign data = (state_q == S_WR) ? wdata_q : 'z;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: random and directed traffic
// against a transaction-level memory/arbiter model.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  localparam int T = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.WORD_SIZE(16), .ADDR_SIZE(16)) b0 ();
  mem_bus_arbiter_if #(.WORD_SIZE(16), .ADDR_SIZE(16)) b1 ();

  wire [15:0] data0;
  wire [15:0] data1;
  logic       drv0 = 1'b0;
  logic [15:0] dval0 = '0;

  assign data0 = drv0 ? dval0 : 'z;
  assign data1 = b1.readM ? 16'h5A5A : 'z;
  assign b1.inputReady = b1.readM;
  assign b1.ackOutput  = b1.writeM;

  mem_bus_arbiter #(
    .WORD_SIZE(16), .ADDR_SIZE(16),
    .TIMEOUT_CYCLES(T), .IF_PRIORITY(0)
  ) dut0 (
    .clk(clk), .reset(reset), .bus(b0), .data(data0)
  );

  mem_bus_arbiter #(
    .WORD_SIZE(16), .ADDR_SIZE(16),
    .TIMEOUT_CYCLES(15), .IF_PRIORITY(1)
  ) dut1 (
    .clk(clk), .reset(reset), .bus(b1), .data(data1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  bit [15:0] mem [bit [15:0]];

  function automatic logic [15:0] rd_mem(input logic [15:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 16'hA5C3;
  endfunction

  // Transaction model state
  bit          act = 0;
  bit          o_if, t_we;
  int          k, w;
  logic [15:0] t_addr, t_wdata;
  int          force_w = 0;
  bit          stray_en = 1;
  int          n_done = 0;
  logic        rst_s = 1'b0;

  always @(posedge clk) rst_s <= reset;

  // Memory responder and transaction checker
  always @(negedge clk) begin : mon
    logic strobe, rdy, err;
    int   lat;
    strobe = b0.readM | b0.writeM;
    rdy    = b0.if_ready | b0.d_ready;
    b0.inputReady = 1'b0;
    b0.ackOutput  = 1'b0;
    drv0 = 1'b0;
    if (rst_s) begin
      act = 0;
      chk("rst_out", {b0.readM, b0.writeM, b0.if_ready,
                      b0.d_ready, b0.bus_err, b0.busy}, 0);
      chk("rst_addr", b0.address, 0);
    end else begin
      chk("busy", b0.busy, strobe | rdy);
      if (strobe && !act) begin
        act    = 1;
        k      = 0;
        o_if   = !b0.d_req;
        t_we   = o_if ? 1'b0 : b0.d_we;
        t_addr = o_if ? b0.if_addr : b0.d_addr;
        t_wdata = b0.d_wdata;
        w = (force_w >= 0) ? force_w : $urandom_range(0, 5);
        chk("dir", {b0.readM, b0.writeM},
            t_we ? 2'b01 : 2'b10);
      end else if (act) begin
        k++;
      end
      if (act && strobe) begin
        chk("addr", b0.address, t_addr);
        if (b0.writeM) chk("wdata", data0, t_wdata);
        if (k == w) begin
          b0.inputReady = b0.readM;
          b0.ackOutput  = b0.writeM;
        end
        if (stray_en && $urandom_range(0, 1) == 1) begin
          if (b0.readM) b0.ackOutput  = 1'b1;
          else          b0.inputReady = 1'b1;
        end
        drv0  = b0.readM;
        dval0 = rd_mem(t_addr);
      end else if (stray_en) begin
        b0.inputReady = 1'($urandom_range(0, 1));
        b0.ackOutput  = 1'($urandom_range(0, 1));
      end
      if (rdy) begin
        if (!act) begin
          chk("spurious_rdy", rdy, 0);
        end else begin
          lat = (w + 1 < T) ? w + 1 : T;
          err = (w + 1 > T);
          chk("latency", k, lat);
          chk("port", {b0.if_ready, b0.d_ready},
              o_if ? 2'b10 : 2'b01);
          chk("gap_strobes", {b0.readM, b0.writeM}, 0);
          chk("bus_err", b0.bus_err, err);
          if (!t_we || err)
            chk("rdata", o_if ? b0.if_data : b0.d_rdata,
                err ? 16'hFFFF : rd_mem(t_addr));
          if (t_we && !err) mem[t_addr] = t_wdata;
          act = 0;
          n_done++;
        end
      end else begin
        chk("err_idle", b0.bus_err, 0);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_rdy0(input bit is_if, output bit err);
    bit seen;
    seen = 0;
    err  = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      tick();
      if (is_if ? b0.if_ready : b0.d_ready) begin
        seen = 1;
        err  = b0.bus_err;
        if (is_if) b0.if_req = 1'b0;
        else       b0.d_req  = 1'b0;
      end
    end
    chk(is_if ? "wait_if" : "wait_d", seen, 1);
  endtask

  bit e;
  int seq0, seq1, nrdy, iss, d0, age_if, age_d, max_age;
  bit got_rd;

  initial begin
    mem[16'h0010] = 16'h6A05;
    {b0.if_req, b0.d_req, b0.d_we} = '0;
    {b0.if_addr, b0.d_addr, b0.d_wdata} = '0;
    {b1.if_req, b1.d_req, b1.d_we} = '0;
    {b1.if_addr, b1.d_addr, b1.d_wdata} = '0;
    b0.inputReady = 1'b0;
    b0.ackOutput  = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    repeat (2) tick();

    // Zero-wait fetch
    force_w = 0;
    b0.if_addr = 16'h0010;
    b0.if_req  = 1'b1;
    wait_rdy0(1, e);
    chk("fetch_data", b0.if_data, 16'h6A05);
    tick();

    // Write with three wait cycles, then read it back
    force_w = 3;
    b0.d_we = 1'b1; b0.d_addr = 16'h0040;
    b0.d_wdata = 16'hBEEF; b0.d_req = 1'b1;
    wait_rdy0(0, e);
    chk("wr_err", e, 0);
    force_w = 1;
    b0.d_we = 1'b0; b0.d_req = 1'b1;
    wait_rdy0(0, e);
    chk("wr_readback", b0.d_rdata, 16'hBEEF);

    // Simultaneous requests on both priority settings
    force_w = 0;
    seq0 = 0; seq1 = 0;
    b0.if_addr = 16'h0022; b0.d_addr = 16'h0041;
    b1.if_addr = 16'h0022; b1.d_addr = 16'h0041;
    b0.d_we = 1'b0; b1.d_we = 1'b0;
    b0.if_req = 1'b1; b0.d_req = 1'b1;
    b1.if_req = 1'b1; b1.d_req = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (b0.if_ready) begin seq0 = seq0*4 + 1; b0.if_req = 1'b0; end
      if (b0.d_ready)  begin seq0 = seq0*4 + 2; b0.d_req  = 1'b0; end
      if (b1.if_ready) begin seq1 = seq1*4 + 1; b1.if_req = 1'b0; end
      if (b1.d_ready)  begin seq1 = seq1*4 + 2; b1.d_req  = 1'b0; end
    end
    chk("arb_prio0", seq0, 9);
    chk("arb_prio1", seq1, 6);
    chk("arb1_ifdata", b1.if_data, 16'h5A5A);
    chk("arb1_drdata", b1.d_rdata, 16'h5A5A);

    // Timeout: silent memory, then response on the expiry edge
    force_w = 9;
    b0.d_addr = 16'h0055; b0.d_req = 1'b1;
    wait_rdy0(0, e);
    chk("to_err", e, 1);
    chk("to_data", b0.d_rdata, 16'hFFFF);
    force_w = 3;
    b0.d_req = 1'b1;
    wait_rdy0(0, e);
    chk("to_edge_err", e, 0);
    chk("to_edge_data", b0.d_rdata, 16'h0055 ^ 16'hA5C3);

    // Reset in the middle of a read
    force_w = 9;
    b0.if_addr = 16'h0077; b0.if_req = 1'b1;
    got_rd = 0;
    for (int c = 0; c < 10 && !got_rd; c++) begin
      tick();
      got_rd = b0.readM;
    end
    chk("rst_rd_start", got_rd, 1);
    tick();
    reset = 1'b1; b0.if_req = 1'b0;
    tick();
    reset = 1'b0;
    nrdy = 0;
    repeat (6) begin
      tick();
      nrdy += int'(b0.if_ready) + int'(b0.d_ready);
    end
    chk("rst_no_rdy", nrdy, 0);
    force_w = 0;
    b0.if_addr = 16'h0010; b0.if_req = 1'b1;
    wait_rdy0(1, e);
    chk("post_rst_fetch", b0.if_data, 16'h6A05);

    // Random traffic
    force_w = -1;
    iss = 0; d0 = n_done;
    age_if = 0; age_d = 0; max_age = 0;
    for (int c = 0; c < 600; c++) begin
      tick();
      if (b0.if_req && b0.if_ready) begin
        b0.if_req = 1'b0; age_if = 0;
      end else if (!b0.if_req && c < 560 &&
                   $urandom_range(0, 2) == 0) begin
        b0.if_addr = 16'($urandom_range(0, 63));
        b0.if_req = 1'b1; iss++;
      end
      if (b0.d_req && b0.d_ready) begin
        b0.d_req = 1'b0; age_d = 0;
      end else if (!b0.d_req && c < 560 &&
                   $urandom_range(0, 2) == 0) begin
        b0.d_addr  = 16'($urandom_range(0, 63));
        b0.d_we    = 1'($urandom_range(0, 1));
        b0.d_wdata = 16'($urandom);
        b0.d_req = 1'b1; iss++;
      end
      if ($urandom_range(0, 7) == 0 && b0.busy) begin
        b0.if_addr = 16'($urandom_range(0, 63));
        b0.d_addr  = 16'($urandom_range(0, 63));
        b0.d_wdata = 16'($urandom);
      end
      if (b0.if_req) age_if++;
      if (b0.d_req)  age_d++;
      if (age_if > max_age) max_age = age_if;
      if (age_d > max_age)  max_age = age_d;
    end
    chk("no_starve", max_age < 30, 1);
    chk("pending_end", {b0.if_req, b0.d_req}, 0);
    chk("done_cnt", n_done - d0, iss);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
